// File: rtl/apb_master_bridge.sv
// ============================================================================
// apb_master_bridge : valid/ready command -> APB SETUP/ACCESS requester
// Optional ACCESS timeout with APB_MASTER_TIMEOUT_EN.  Revision: 1.0
// ============================================================================
`default_nettype none

module apb_master_bridge #(
  parameter int ADDR_BUS_WIDTH = 32,
  parameter int DATA_BUS_WIDTH = 32,
  parameter int TIMEOUT_CYC    = 16
) (
  input  logic                      PCLK,
  input  logic                      PRESETn,
  input  logic                      cmd_valid,
  output logic                      cmd_ready,
  input  logic                      cmd_write,
  input  logic [ADDR_BUS_WIDTH-1:0] cmd_addr,
  input  logic [DATA_BUS_WIDTH-1:0] cmd_wdata,
  output logic                      rsp_valid,
  input  logic                      rsp_ready,
  output logic [DATA_BUS_WIDTH-1:0] rsp_rdata,
  output logic                      rsp_err,
  output logic                      PSEL,
  output logic                      PENABLE,
  output logic                      PWRITE,
  output logic [ADDR_BUS_WIDTH-1:0] PADDR,
  output logic [DATA_BUS_WIDTH-1:0] PWDATA,
  input  logic [DATA_BUS_WIDTH-1:0] PRDATA,
  input  logic                      PREADY,
  input  logic                      PSLVERR
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SETUP  = 2'd1,
    S_ACCESS = 2'd2,
    S_RESP   = 2'd3
  } state_t;

  state_t                    r_state, w_state_nxt;
  logic                      r_cmd_ready, w_cmd_ready_nxt;
  logic                      r_rsp_valid, w_rsp_valid_nxt;
  logic [DATA_BUS_WIDTH-1:0] r_rsp_rdata, w_rsp_rdata_nxt;
  logic                      r_rsp_err, w_rsp_err_nxt;
  logic                      r_psel, w_psel_nxt;
  logic                      r_penable, w_penable_nxt;
  logic                      r_pwrite, w_pwrite_nxt;
  logic [ADDR_BUS_WIDTH-1:0] r_paddr, w_paddr_nxt;
  logic [DATA_BUS_WIDTH-1:0] r_pwdata, w_pwdata_nxt;
  logic                      w_timeout;

`ifdef APB_MASTER_TIMEOUT_EN
  localparam int CNT_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [CNT_W-1:0] C_CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;

  // Counter is zero on entry to ACCESS and counts ACCESS cycles spent waiting.
  always_comb begin
    w_cnt_nxt = '0;
    if (r_state == S_ACCESS) begin
      w_cnt_nxt = r_cnt + CNT_W'(1);
    end
  end

  assign w_timeout = (r_state == S_ACCESS) && (r_cnt == C_CNT_LAST);

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= w_cnt_nxt;
    end
  end
`else
  logic w_unused_timeout_cyc;
  assign w_unused_timeout_cyc = (TIMEOUT_CYC != 0);
  assign w_timeout            = 1'b0;
`endif

  always_comb begin
    w_state_nxt     = r_state;
    w_cmd_ready_nxt = r_cmd_ready;
    w_rsp_valid_nxt = r_rsp_valid;
    w_rsp_rdata_nxt = r_rsp_rdata;
    w_rsp_err_nxt   = r_rsp_err;
    w_psel_nxt      = r_psel;
    w_penable_nxt   = r_penable;
    w_pwrite_nxt    = r_pwrite;
    w_paddr_nxt     = r_paddr;
    w_pwdata_nxt    = r_pwdata;

    case (r_state)
      S_IDLE: begin
        w_cmd_ready_nxt = 1'b1;
        if (r_cmd_ready && cmd_valid) begin
          w_cmd_ready_nxt = 1'b0;
          w_psel_nxt      = 1'b1;
          w_pwrite_nxt    = cmd_write;
          w_paddr_nxt     = cmd_addr;
          w_pwdata_nxt    = cmd_wdata;
          w_state_nxt     = S_SETUP;
        end
      end
      // PREADY/PSLVERR are deliberately not looked at during SETUP.
      S_SETUP: begin
        w_penable_nxt = 1'b1;
        w_state_nxt   = S_ACCESS;
      end
      S_ACCESS: begin
        if (PREADY) begin
          w_rsp_err_nxt   = PSLVERR;
          w_rsp_rdata_nxt = r_pwrite ? '0 : PRDATA;
          w_rsp_valid_nxt = 1'b1;
          w_psel_nxt      = 1'b0;
          w_penable_nxt   = 1'b0;
          w_state_nxt     = S_RESP;
        end else if (w_timeout) begin
          w_rsp_err_nxt   = 1'b1;
          w_rsp_rdata_nxt = '0;
          w_rsp_valid_nxt = 1'b1;
          w_psel_nxt      = 1'b0;
          w_penable_nxt   = 1'b0;
          w_state_nxt     = S_RESP;
        end
      end
      S_RESP: begin
        if (rsp_ready) begin
          w_rsp_valid_nxt = 1'b0;
          w_cmd_ready_nxt = 1'b1;
          w_state_nxt     = S_IDLE;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      r_state     <= S_IDLE;
      r_cmd_ready <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_rsp_rdata <= '0;
      r_rsp_err   <= 1'b0;
      r_psel      <= 1'b0;
      r_penable   <= 1'b0;
      r_pwrite    <= 1'b0;
      r_paddr     <= '0;
      r_pwdata    <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_cmd_ready <= w_cmd_ready_nxt;
      r_rsp_valid <= w_rsp_valid_nxt;
      r_rsp_rdata <= w_rsp_rdata_nxt;
      r_rsp_err   <= w_rsp_err_nxt;
      r_psel      <= w_psel_nxt;
      r_penable   <= w_penable_nxt;
      r_pwrite    <= w_pwrite_nxt;
      r_paddr     <= w_paddr_nxt;
      r_pwdata    <= w_pwdata_nxt;
    end
  end

  assign cmd_ready = r_cmd_ready;
  assign rsp_valid = r_rsp_valid;
  assign rsp_rdata = r_rsp_rdata;
  assign rsp_err   = r_rsp_err;
  assign PSEL      = r_psel;
  assign PENABLE   = r_penable;
  assign PWRITE    = r_pwrite;
  assign PADDR     = r_paddr;
  assign PWDATA    = r_pwdata;

endmodule

`default_nettype wire

// File: tb/tb_apb_master_bridge.sv
// ============================================================================
// tb_apb_master_bridge : directed bench with response scoreboard and APB slave
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_apb_master_bridge;

  localparam int MEMSIZE = 64;

  logic        PCLK;
  logic        PRESETn;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_write;
  logic [31:0] cmd_addr;
  logic [31:0] cmd_wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        PSEL;
  logic        PENABLE;
  logic        PWRITE;
  logic [31:0] PADDR;
  logic [31:0] PWDATA;
  logic [31:0] PRDATA;
  logic        PREADY;
  logic        PSLVERR;

  apb_master_bridge #(
    .ADDR_BUS_WIDTH(32),
    .DATA_BUS_WIDTH(32),
    .TIMEOUT_CYC   (4)
  ) dut (
    .PCLK     (PCLK),
    .PRESETn  (PRESETn),
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .cmd_write(cmd_write),
    .cmd_addr (cmd_addr),
    .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready),
    .rsp_rdata(rsp_rdata),
    .rsp_err  (rsp_err),
    .PSEL     (PSEL),
    .PENABLE  (PENABLE),
    .PWRITE   (PWRITE),
    .PADDR    (PADDR),
    .PWDATA   (PWDATA),
    .PRDATA   (PRDATA),
    .PREADY   (PREADY),
    .PSLVERR  (PSLVERR)
  );

  initial begin
    PCLK = 1'b0;
    forever #5 PCLK = ~PCLK;
  end

  // Simple SRAM-like slave: wait_req ACCESS wait states, hang forces PREADY low.
  logic [31:0] mem [MEMSIZE];
  int          acc_cnt;
  int          wait_req;
  logic        hang;

  always_comb begin
    PREADY  = PSEL && !hang && (!PENABLE || (acc_cnt >= wait_req));
    PSLVERR = PSEL && (PADDR >= 32'(MEMSIZE));
    PRDATA  = (PADDR < 32'(MEMSIZE)) ? mem[PADDR[5:0]] : 32'h0;
  end

  always @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      acc_cnt <= 0;
    end else begin
      if (PSEL && PENABLE && !PREADY) acc_cnt <= acc_cnt + 1;
      else                            acc_cnt <= 0;
      if (PSEL && PENABLE && PREADY && PWRITE && (PADDR < 32'(MEMSIZE)))
        mem[PADDR[5:0]] <= PWDATA;
    end
  end

  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge after the accept edge (SETUP).
  task automatic send(input logic w, input logic [31:0] a, input logic [31:0] d,
                      input logic [31:0] exp_rdata, input logic exp_err, input logic push);
    int n;
    cmd_valid = 1'b1;
    cmd_write = w;
    cmd_addr  = a;
    cmd_wdata = d;
    n = 0;
    while (cmd_ready !== 1'b1 && n < 20) begin
      @(negedge PCLK);
      n++;
    end
    chk("cmd_ready_wait", 32'(n < 20), 32'd1);
    @(posedge PCLK);
    if (push) sb.push_back('{rdata: exp_rdata, err: exp_err});
    @(negedge PCLK);
    cmd_valid = 1'b0;
  endtask

  // Called at a negedge; waits for rsp_valid, scores it, completes the handshake.
  task automatic get_rsp(input string tag, output int cyc);
    exp_t e;
    cyc = 0;
    while (rsp_valid !== 1'b1 && cyc < 40) begin
      @(negedge PCLK);
      cyc++;
    end
    chk({tag, "_rsp_wait"}, 32'(cyc < 40), 32'd1);
    chk({tag, "_psel_low"}, {31'd0, PSEL | PENABLE}, 32'd0);
    chk({tag, "_sb_nonempty"}, 32'(sb.size() > 0), 32'd1);
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk({tag, "_rdata"}, rsp_rdata, e.rdata);
      chk({tag, "_err"}, {31'd0, rsp_err}, {31'd0, e.err});
    end
    rsp_ready = 1'b1;
    @(posedge PCLK);
    @(negedge PCLK);
    rsp_ready = 1'b0;
    chk({tag, "_rsp_cleared"}, {31'd0, rsp_valid}, 32'd0);
    chk({tag, "_cmd_ready_back"}, {31'd0, cmd_ready}, 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc;
    int n;
    logic any_rsp;

    PRESETn   = 1'b0;
    cmd_valid = 1'b0;
    cmd_write = 1'b0;
    cmd_addr  = 32'h0;
    cmd_wdata = 32'h0;
    rsp_ready = 1'b0;
    hang      = 1'b0;
    wait_req  = 0;

    repeat (2) @(negedge PCLK);
    chk("rst_cmd_ready", {31'd0, cmd_ready}, 32'd0);
    chk("rst_outputs", {28'd0, PSEL, PENABLE, rsp_valid, rsp_err}, 32'd0);
    PRESETn = 1'b1;
    @(negedge PCLK);
    chk("post_rst_cmd_ready", {31'd0, cmd_ready}, 32'd1);

    // Zero-wait write: SETUP then one ACCESS cycle, response after the next edge.
    send(1'b1, 32'h10, 32'hDEADBEEF, 32'h0, 1'b0, 1'b1);
    chk("wr_setup_psel", {30'd0, PSEL, PENABLE}, 32'b10);
    chk("wr_setup_paddr", PADDR, 32'h10);
    chk("wr_setup_pwdata", PWDATA, 32'hDEADBEEF);
    chk("wr_setup_cmd_ready", {31'd0, cmd_ready}, 32'd0);
    @(negedge PCLK);
    chk("wr_access_psel", {29'd0, PSEL, PENABLE, PWRITE}, 32'b111);
    get_rsp("wr10", cyc);
    chk("wr10_latency", cyc, 32'd1);

    send(1'b0, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0, 1'b1);
    get_rsp("rd10", cyc);
    chk("rd10_latency", cyc, 32'd2);

    // Out-of-range read returns the slave error, then the bridge recovers.
    send(1'b0, 32'h40, 32'h0, 32'h0, 1'b1, 1'b1);
    get_rsp("rd40", cyc);
    send(1'b0, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0, 1'b1);
    get_rsp("rd10_again", cyc);

    // Two wait states: three stable ACCESS cycles.
    wait_req = 2;
    send(1'b1, 32'h20, 32'h12345678, 32'h0, 1'b0, 1'b1);
    @(negedge PCLK);
    n = 0;
    while (PENABLE === 1'b1 && n < 10) begin
      chk("ws_stable_psel", {31'd0, PSEL}, 32'd1);
      chk("ws_stable_paddr", PADDR, 32'h20);
      chk("ws_stable_pwdata", PWDATA, 32'h12345678);
      n++;
      @(negedge PCLK);
    end
    chk("ws_access_cycles", n, 32'd3);
    get_rsp("wr20_ws", cyc);
    chk("wr20_ws_latency", cyc, 32'd0);
    wait_req = 0;
    send(1'b0, 32'h20, 32'h0, 32'h12345678, 1'b0, 1'b1);
    get_rsp("rd20", cyc);

    // Response backpressure with a competing command pending.
    send(1'b0, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0, 1'b1);
    n = 0;
    while (rsp_valid !== 1'b1 && n < 10) begin
      @(negedge PCLK);
      n++;
    end
    cmd_valid = 1'b1;
    cmd_write = 1'b1;
    cmd_addr  = 32'h30;
    cmd_wdata = 32'hCAFEF00D;
    for (int i = 0; i < 5; i++) begin
      chk("bp_rsp_valid", {31'd0, rsp_valid}, 32'd1);
      chk("bp_rsp_rdata", rsp_rdata, 32'hDEADBEEF);
      chk("bp_no_accept", {30'd0, cmd_ready, PSEL}, 32'd0);
      @(negedge PCLK);
    end
    get_rsp("rd10_bp", cyc);
    send(1'b1, 32'h30, 32'hCAFEF00D, 32'h0, 1'b0, 1'b1);
    chk("bp_next_paddr", PADDR, 32'h30);
    get_rsp("wr30", cyc);

    // Reset during ACCESS drops the transfer.
    hang = 1'b1;
    send(1'b0, 32'h10, 32'h0, 32'h0, 1'b0, 1'b0);
    @(negedge PCLK);
    @(negedge PCLK);
    chk("mid_rst_in_access", {30'd0, PSEL, PENABLE}, 32'b11);
    #2 PRESETn = 1'b0;
    #1;
    chk("mid_rst_ctrl", {26'd0, cmd_ready, PSEL, PENABLE, PWRITE, rsp_valid, rsp_err}, 32'd0);
    chk("mid_rst_paddr", PADDR, 32'h0);
    chk("mid_rst_data", PWDATA | rsp_rdata, 32'h0);
    @(negedge PCLK);
    PRESETn = 1'b1;
    hang    = 1'b0;
    any_rsp = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge PCLK);
      any_rsp = any_rsp | rsp_valid;
    end
    chk("mid_rst_no_rsp", {31'd0, any_rsp}, 32'd0);
    chk("mid_rst_cmd_ready", {31'd0, cmd_ready}, 32'd1);
    send(1'b0, 32'h20, 32'h0, 32'h12345678, 1'b0, 1'b1);
    get_rsp("rd20_after_rst", cyc);

`ifdef APB_MASTER_TIMEOUT_EN
    // Stuck slave: abort after four ACCESS cycles.
    hang = 1'b1;
    send(1'b0, 32'h20, 32'h0, 32'h0, 1'b1, 1'b1);
    get_rsp("timeout", cyc);
    chk("timeout_latency", cyc, 32'd5);
    hang = 1'b0;
    send(1'b0, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0, 1'b1);
    get_rsp("rd10_after_timeout", cyc);
`endif

    chk("sb_empty", sb.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
